// File: rtl/ram_sp_unaligned.sv
// Single-port 32-bit RAM with a req/gnt/rvalid handshake. Accesses that cross a
// word boundary are split into two back-to-back word accesses.
module ram_sp_unaligned #(
    parameter int SIZE       = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o
);

    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] SIZE_W = ADDR_WIDTH'(SIZE);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    state_e                  state_r;
    logic [31:0]             mem_r [SIZE];
    logic [31:0]             rd_word_r;
    logic [31:0]             lo_word_r;
    logic [31:0]             hold_r;
    logic                    rvalid_r;
    logic                    err_r;
    logic                    zero_r;
    logic                    cross_r;
    logic [1:0]              off_r;
    logic [3:0]              be_r;
    logic [IW-1:0]           split_idx_r;
    logic                    split_we_r;
    logic [3:0]              split_be_r;
    logic [31:0]             split_wd_r;

    logic [1:0]              off_s;
    logic [ADDR_WIDTH-1:0]   word_s;
    logic [7:0]              mask_s;
    logic [63:0]             wd64_s;
    logic                    cross_s;
    logic                    oor_s;
    logic                    accept_s;
    logic                    acc_en_s;
    logic                    acc_we_s;
    logic [3:0]              acc_be_s;
    logic [IW-1:0]           acc_idx_s;
    logic [31:0]             acc_wd_s;
    logic [63:0]             pair_s;
    logic [63:0]             shifted_s;
    logic [31:0]             rdata_s;

    // Lane math: 8-bit mask over words w and w+1, range check, accept.
    always_comb begin
        off_s    = addr_i[1:0];
        word_s   = {2'b00, addr_i[ADDR_WIDTH-1:2]};
        mask_s   = {4'b0000, be_i} << off_s;
        wd64_s   = {32'h0000_0000, wdata_i} << {off_s, 3'b000};
        cross_s  = |mask_s[7:4];
        oor_s    = (word_s >= SIZE_W) ||
                   (cross_s && ((word_s + ADDR_WIDTH'(1)) >= SIZE_W));
        accept_s = req_i && (state_r == IDLE);
    end

    // Array port mux; gated by rstn_i so a reset in SPLIT drops the second half.
    always_comb begin
        acc_en_s  = 1'b0;
        acc_we_s  = 1'b0;
        acc_be_s  = 4'b0000;
        acc_idx_s = '0;
        acc_wd_s  = 32'h0000_0000;
        if (state_r == SPLIT) begin
            acc_en_s  = rstn_i;
            acc_we_s  = split_we_r;
            acc_be_s  = split_be_r;
            acc_idx_s = split_idx_r;
            acc_wd_s  = split_wd_r;
        end else if (accept_s && !oor_s && (be_i != 4'b0000)) begin
            acc_en_s  = rstn_i;
            acc_we_s  = we_i;
            acc_be_s  = mask_s[3:0];
            acc_idx_s = word_s[IW-1:0];
            acc_wd_s  = wd64_s[31:0];
        end else begin
            acc_en_s  = 1'b0;
        end
    end

    // Block RAM: byte-enabled write, synchronous read; contents are not reset.
    always_ff @(posedge clk) begin
        if (acc_en_s) begin
            if (acc_we_s) begin
                for (int k = 0; k < 4; k++) begin
                    if (acc_be_s[k]) begin
                        mem_r[acc_idx_s][8*k +: 8] <= acc_wd_s[8*k +: 8];
                    end
                end
            end else begin
                rd_word_r <= mem_r[acc_idx_s];
            end
        end
    end

    // Handshake FSM and response registers.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r     <= IDLE;
            rvalid_r    <= 1'b0;
            err_r       <= 1'b0;
            zero_r      <= 1'b1;
            cross_r     <= 1'b0;
            off_r       <= 2'b00;
            be_r        <= 4'b0000;
            lo_word_r   <= 32'h0000_0000;
            hold_r      <= 32'h0000_0000;
            split_idx_r <= '0;
            split_we_r  <= 1'b0;
            split_be_r  <= 4'b0000;
            split_wd_r  <= 32'h0000_0000;
        end else begin
            if (rvalid_r) begin
                hold_r <= rdata_s;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        off_r <= off_s;
                        be_r  <= be_i;
                        if (cross_s && !oor_s) begin
                            state_r     <= SPLIT;
                            rvalid_r    <= 1'b0;
                            err_r       <= 1'b0;
                            split_idx_r <= word_s[IW-1:0] + IW'(1);
                            split_we_r  <= we_i;
                            split_be_r  <= mask_s[7:4];
                            split_wd_r  <= wd64_s[63:32];
                        end else begin
                            rvalid_r <= 1'b1;
                            err_r    <= oor_s;
                            zero_r   <= we_i || oor_s || (be_i == 4'b0000);
                            cross_r  <= 1'b0;
                        end
                    end else begin
                        rvalid_r <= 1'b0;
                        err_r    <= 1'b0;
                    end
                end
                SPLIT: begin
                    // rd_word_r still holds word w here; park it before w+1 lands.
                    state_r   <= IDLE;
                    rvalid_r  <= 1'b1;
                    err_r     <= 1'b0;
                    zero_r    <= split_we_r;
                    cross_r   <= 1'b1;
                    lo_word_r <= rd_word_r;
                end
                default: begin
                    state_r  <= IDLE;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

    // Realign the one or two fetched words back to requester byte order.
    always_comb begin
        pair_s    = cross_r ? {rd_word_r, lo_word_r} : {32'h0000_0000, rd_word_r};
        shifted_s = pair_s >> {off_r, 3'b000};
        for (int k = 0; k < 4; k++) begin
            rdata_s[8*k +: 8] = (be_r[k] && !zero_r) ? shifted_s[8*k +: 8] : 8'h00;
        end
        rdata_o = rvalid_r ? rdata_s : hold_r;
    end

    assign gnt_o    = (state_r == IDLE);
    assign rvalid_o = rvalid_r;
    assign err_o    = err_r;

endmodule

// File: tb/tb_ram_sp_unaligned.sv
// Directed bench for ram_sp_unaligned: request lists driven back-to-back,
// responses collected with their cycle numbers and checked against hand values.
module tb_ram_sp_unaligned;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    ram_sp_unaligned #(.SIZE(1024), .ADDR_WIDTH(32)) dut (
        .clk      (clk),
        .rstn_i   (rstn_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic gnt_log [4096];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) gnt_log[cyc % 4096] <= gnt_o;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic        q_we   [16];
    logic [3:0]  q_be   [16];
    logic [31:0] q_addr [16];
    logic [31:0] q_wd   [16];
    int          acc_cyc[16];
    logic [31:0] r_data [16];
    logic        r_err  [16];
    int          r_cyc  [16];
    int          n_req = 0;
    int          n_rsp = 0;
    int          bubbles = 0;

    task automatic clear();
        n_req = 0;
    endtask

    task automatic add(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
        q_we[n_req]   = we;
        q_be[n_req]   = be;
        q_addr[n_req] = addr;
        q_wd[n_req]   = wd;
        n_req++;
    endtask

    task automatic run();
        bubbles = 0;
        n_rsp   = 0;
        fork
            begin
                for (int i = 0; i < n_req; i++) begin
                    @(negedge clk);
                    req_i   = 1'b1;
                    we_i    = q_we[i];
                    be_i    = q_be[i];
                    addr_i  = q_addr[i];
                    wdata_i = q_wd[i];
                    for (int t = 0; t < 8 && !gnt_o; t++) begin
                        bubbles++;
                        @(negedge clk);
                    end
                    if (!gnt_o) check("gnt_timeout", 32'(gnt_o), 32'd1);
                    acc_cyc[i] = cyc;
                    @(posedge clk);
                end
                @(negedge clk);
                req_i = 1'b0;
                we_i  = 1'b0;
                be_i  = 4'b0000;
            end
            begin
                repeat (3 * n_req + 6) begin
                    @(negedge clk);
                    if (rvalid_o && n_rsp < 16) begin
                        r_data[n_rsp] = rdata_o;
                        r_err[n_rsp]  = err_o;
                        r_cyc[n_rsp]  = cyc;
                        n_rsp++;
                    end
                end
            end
        join
        check("rsp_count", 32'(n_rsp), 32'(n_req));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rstn_i  = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'b0000;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_err",    32'(err_o),    32'd0);
        check("rst_rdata",  rdata_o,       32'h0);
        check("rst_gnt",    32'(gnt_o),    32'd1);
        rstn_i = 1'b1;
        @(negedge clk);

        // Aligned write then read in the next cycle
        clear();
        add(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        add(1'b0, 4'hF, 32'h10, 32'h0);
        run();
        check("A_wr_rdata", r_data[0], 32'h0);
        check("A_wr_err",   32'(r_err[0]), 32'd0);
        check("A_rd_data",  r_data[1], 32'hDEADBEEF);
        check("A_rd_err",   32'(r_err[1]), 32'd0);
        check("A_b2b",      32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
        check("A_lat",      32'(r_cyc[1] - acc_cyc[1]), 32'd1);
        check("A_bubbles",  32'(bubbles), 32'd0);

        // Crossing write and read
        clear();
        add(1'b1, 4'hF, 32'h10, 32'h0);
        add(1'b1, 4'hF, 32'h14, 32'h0);
        run();
        clear();
        add(1'b1, 4'hF, 32'h13, 32'h44332211);
        run();
        check("B_gnt_split", 32'(gnt_log[(acc_cyc[0] + 1) % 4096]), 32'd0);
        check("B_wr_lat",    32'(r_cyc[0] - acc_cyc[0]), 32'd2);
        check("B_wr_err",    32'(r_err[0]), 32'd0);
        check("B_wr_rdata",  r_data[0], 32'h0);
        clear();
        add(1'b0, 4'hF, 32'h10, 32'h0);
        add(1'b0, 4'hF, 32'h14, 32'h0);
        add(1'b0, 4'hF, 32'h13, 32'h0);
        run();
        check("B_word4",  r_data[0], 32'h11000000);
        check("B_word5",  r_data[1], 32'h00443322);
        check("B_rd_x",   r_data[2], 32'h44332211);
        check("B_rd_lat", 32'(r_cyc[2] - acc_cyc[2]), 32'd2);

        // Partial lanes
        clear();
        add(1'b1, 4'hF, 32'h20, 32'hAABBCCDD);
        add(1'b1, 4'hF, 32'h24, 32'h0);
        add(1'b0, 4'h3, 32'h21, 32'h0);
        run();
        check("C_rd_part", r_data[2], 32'h0000BBCC);
        check("C_rd_lat",  32'(r_cyc[2] - acc_cyc[2]), 32'd1);
        clear();
        add(1'b1, 4'h3, 32'h23, 32'h00001234);
        add(1'b0, 4'hF, 32'h20, 32'h0);
        add(1'b0, 4'hF, 32'h24, 32'h0);
        run();
        check("C_word8", r_data[1], 32'h34BBCCDD);
        check("C_word9", r_data[2], 32'h00000012);

        // Out of range and empty byte enables
        clear();
        add(1'b1, 4'hF, 32'hFFC,  32'hCAFEF00D);
        add(1'b0, 4'hF, 32'h1000, 32'h0);
        add(1'b1, 4'hF, 32'hFFE,  32'h11223344);
        add(1'b0, 4'hF, 32'hFFC,  32'h0);
        add(1'b0, 4'h0, 32'h10,   32'h0);
        run();
        check("D_oor_err",    32'(r_err[1]), 32'd1);
        check("D_oor_rdata",  r_data[1], 32'h0);
        check("D_oor_lat",    32'(r_cyc[1] - acc_cyc[1]), 32'd1);
        check("D_oorx_err",   32'(r_err[2]), 32'd1);
        check("D_oorx_lat",   32'(r_cyc[2] - acc_cyc[2]), 32'd1);
        check("D_w1023",      r_data[3], 32'hCAFEF00D);
        check("D_w1023_err",  32'(r_err[3]), 32'd0);
        check("D_be0_rdata",  r_data[4], 32'h0);
        check("D_be0_err",    32'(r_err[4]), 32'd0);
        check("D_be0_lat",    32'(r_cyc[4] - acc_cyc[4]), 32'd1);
        check("D_bubbles",    32'(bubbles), 32'd0);

        // Streaming aligned reads
        clear();
        for (int i = 0; i < 8; i++) add(1'b1, 4'hF, 32'(4 * i), 32'hA0000000 + 32'(i));
        run();
        clear();
        for (int i = 0; i < 8; i++) add(1'b0, 4'hF, 32'(4 * i), 32'h0);
        run();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("E_data%0d", i), r_data[i], 32'hA0000000 + 32'(i));
            check($sformatf("E_cyc%0d", i), 32'(r_cyc[i] - r_cyc[0]), 32'(i));
        end
        check("E_bubbles", 32'(bubbles), 32'd0);

        // One crossing read inside a stream
        clear();
        add(1'b0, 4'hF, 32'h0, 32'h0);
        add(1'b0, 4'hF, 32'h4, 32'h0);
        add(1'b0, 4'hF, 32'h6, 32'h0);
        add(1'b0, 4'hF, 32'h8, 32'h0);
        add(1'b0, 4'hF, 32'hC, 32'h0);
        run();
        check("E2_bubbles", 32'(bubbles), 32'd1);
        check("E2_d0", r_data[0], 32'hA0000000);
        check("E2_d1", r_data[1], 32'hA0000001);
        check("E2_d2", r_data[2], 32'h0002A000);
        check("E2_d3", r_data[3], 32'hA0000002);
        check("E2_d4", r_data[4], 32'hA0000003);

        // Reset during the second half of a crossing write
        clear();
        add(1'b1, 4'hF, 32'h10, 32'h0);
        add(1'b1, 4'hF, 32'h14, 32'h55555555);
        run();
        @(negedge clk);
        req_i   = 1'b1;
        we_i    = 1'b1;
        be_i    = 4'hF;
        addr_i  = 32'h13;
        wdata_i = 32'h44332211;
        check("F_gnt_pre", 32'(gnt_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("F_gnt_split", 32'(gnt_o), 32'd0);
        rstn_i = 1'b0;
        req_i  = 1'b0;
        we_i   = 1'b0;
        be_i   = 4'h0;
        @(negedge clk);
        check("F_rvalid_rst", 32'(rvalid_o), 32'd0);
        rstn_i = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rvalid_o) seen++;
        end
        check("F_no_rvalid", 32'(seen), 32'd0);
        check("F_gnt_post",  32'(gnt_o), 32'd1);
        clear();
        add(1'b0, 4'hF, 32'h10, 32'h0);
        add(1'b0, 4'hF, 32'h14, 32'h0);
        run();
        check("F_word4", r_data[0], 32'h11000000);
        check("F_word5", r_data[1], 32'h55555555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_sp_unaligned.md
Name: ram_sp_unaligned

Overview:
- Parametrised single-port 32-bit block RAM with a req/gnt/rvalid handshake and arbitrary byte-lane enables.
- Unaligned accesses that cross a word boundary are split into two back-to-back word accesses by a small FSM, so the array maps onto true single-port BRAM with synchronous read.
- Serves as the instruction/data memory behind the core's LSU and fetch unit, and adds out-of-range error reporting.

Parameters:
- SIZE, 1024, number of 32-bit words in the array.
- ADDR_WIDTH, 32, byte-address width; word index is addr_i[ADDR_WIDTH-1:2].

Ports:
- clk  input  1  clock
- rstn_i  input  1  asynchronous active-low reset
- req_i  input  1  access request; held by requester until granted
- gnt_o  output  1  request accepted this cycle when req_i && gnt_o
- we_i  input  1  1 = write, 0 = read
- be_i  input  4  byte enables relative to addr_i (bit k = byte addr_i+k)
- addr_i  input  ADDR_WIDTH  byte address, any alignment
- wdata_i  input  32  write data, byte k goes to address addr_i+k
- rvalid_o  output  1  one-cycle response pulse, reads and writes
- rdata_o  output  32  read data, valid with rvalid_o
- err_o  output  1  out-of-range flag, valid with rvalid_o

Behaviour:
- Reset (async, rstn_i=0): state IDLE; rvalid_o=0, err_o=0, rdata_o=0. gnt_o=1 once in IDLE. Memory contents are not reset.
- Lane math: o=addr_i[1:0], w=word index, 8-bit mask m = be_i << o. m[3:0] targets word w, m[7:4] targets word w+1. Access is crossing iff m[7:4]!=0.
- FSM has two states, IDLE and SPLIT.
- IDLE: gnt_o=1.
  - Non-crossing accept in cycle N: single array access in N; rvalid_o in N+1; stay IDLE.
  - Crossing accept in N: word w accessed in N; go to SPLIT.
- SPLIT: gnt_o=0; word w+1 accessed; return to IDLE; rvalid_o in N+2.
- Throughput: back-to-back non-crossing requests run one per cycle. A crossing request costs 2 cycles.
- Read data: rdata_o byte k = mem byte (addr_i+k) if be_i[k], else 0. Array reads are synchronous. The first half of a crossing read is registered until the second half returns.
- Writes: only enabled bytes are written, at the clock edge ending each access cycle. Crossing: low part at the end of N, high part at the end of N+1. A read accepted the cycle after a write's last edge sees the new data. A write response has rdata_o=0, err_o=0.
- Out of range: w>=SIZE, or crossing with w+1>=SIZE.
  - No array access and no partial write.
  - Single-cycle path: rvalid_o in N+1 with err_o=1, rdata_o=0.
  - No wrap-around to word 0.
- be_i=0: no array access; rvalid_o in N+1, err_o=0, rdata_o=0.
- req_i while gnt_o=0 is ignored; the request is re-sampled in the next IDLE cycle.
- Reset during SPLIT: second half abandoned, no rvalid_o. A first-half write that already committed stays in memory.
- rvalid_o and err_o are single-cycle pulses. rdata_o holds its last value until the next response.

Test Plan:
- Aligned word write then read: write addr 0x10, be 1111, wdata 0xDEADBEEF in N; read 0x10 in N+1 → rvalid N+2, rdata 0xDEADBEEF, err 0. gnt stays 1 throughout.
- Crossing write/read: preload words 4,5 = 0; write addr 0x13, be 1111, wdata 0x44332211.
  - Required gnt_o=0 in N+1 and rvalid in N+2.
  - Then word4=0x11000000, word5=0x00443322.
  - Read addr 0x13, be 1111 → rdata 0x44332211 two cycles after accept.
- Partial lanes: word 8 = 0xAABBCCDD; read addr 0x21, be 0011 → rdata 0x0000BBCC, single-cycle latency. Write addr 0x23, be 0011, wdata 0x1234 → word8[31:24]=0x34, word9[7:0]=0x12.
- Out of range (SIZE=1024): read addr 0x1000 → rvalid N+1, err 1, rdata 0. Write addr 0xFFE, be 1111 (crossing past the end) → err 1, word 1023 unchanged.
- Streaming: 8 back-to-back aligned reads at 0x0..0x1C → 8 consecutive rvalid pulses with matching data.
  - Insert one crossing read mid-stream → exactly one gnt_o=0 bubble, and responses stay in order.
- Reset mid-split: assert rstn_i=0 in the SPLIT cycle of a crossing write to 0x13 → no rvalid. After release, word4 holds the first-half bytes, word5 is unchanged, and gnt_o=1.
